pe_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single PE array command interface between NUM_REQ requesters, such as control-unit lanes or DMA-side compute requests. It accepts one command at a time, issues it to the PE array interface with a valid/ready handshake, and waits for the PE done pulse. It then returns the result to the requester that issued the command. Only one command is outstanding at any time.

---
 rtl/instr_pkg.sv | 10 +
 rtl/nmcu_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 28 ++
 rtl/pe_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_pe_req_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared PE instruction word. The arbiter only passes it through to the PE array.
package instr_pkg;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] dst;
      logic [7:0] imm;
   } instruction_t;

endpackage

// File: rtl/nmcu_pkg.sv
// NMCU-wide constants and the request-arbiter state encoding.
package nmcu_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int PERF_CNT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit at or above ptr_i, wrapping.
module rr_priority_picker #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [ID_WIDTH-1:0] ptr_i,
   output logic                grant_valid_o,
   output logic [ID_WIDTH-1:0] grant_idx_o
);

   logic [ID_WIDTH-1:0] idx;

   // Scan from the farthest offset down so the closest request to ptr_i wins last.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      idx           = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ID_WIDTH'((int'(ptr_i) + i) % NUM_REQ);
         if (req_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = idx;
         end
      end
   end

endmodule

// File: rtl/pe_req_arbiter.sv
// Round-robin arbiter sharing the PE command interface, one command outstanding at a time.
// Optional per-requester grant counters are built when NMCU_ARB_PERF_CNT_EN is defined.
module pe_req_arbiter
   import instr_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   input  instruction_t          req_cmd_i       [NUM_REQ],
   input  logic [DATA_WIDTH-1:0] req_operand_a_i [NUM_REQ],
   input  logic [DATA_WIDTH-1:0] req_operand_b_i [NUM_REQ],
   output logic [NUM_REQ-1:0]    req_ready_o,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_result_o,
   output logic [ID_WIDTH-1:0]   rsp_id_o,
   output logic                  pe_cmd_valid_o,
   output instruction_t          pe_cmd_o,
   output logic [DATA_WIDTH-1:0] pe_operand_a_o,
   output logic [DATA_WIDTH-1:0] pe_operand_b_o,
   input  logic                  pe_cmd_ready_i,
   input  logic                  pe_done_i,
   input  logic [DATA_WIDTH-1:0] pe_result_i,
`ifdef NMCU_ARB_PERF_CNT_EN
   output logic                  busy_o,
   input  logic                  perf_clr_i,
   output logic [nmcu_pkg::PERF_CNT_WIDTH-1:0] perf_grant_cnt_o [NUM_REQ]
`else
   output logic                  busy_o
`endif
);

   import nmcu_pkg::*;

   arb_state_e            state_q;
   logic [ID_WIDTH-1:0]   rr_ptr_q;
   logic [ID_WIDTH-1:0]   gnt_id_q;
   instruction_t          cmd_q;
   logic [DATA_WIDTH-1:0] opa_q;
   logic [DATA_WIDTH-1:0] opb_q;
   logic [DATA_WIDTH-1:0] result_q;

   logic                  grant_valid;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic                  accept;

   rr_priority_picker #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_picker (
      .req_i         (req_valid_i),
      .ptr_i         (rr_ptr_q),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
   );

   // Gating with rst keeps the accept pulse low while reset is held with requests pending.
   assign accept = (state_q == IDLE) && grant_valid && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gnt_id_q <= '0;
         cmd_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cmd_q    <= req_cmd_i[grant_idx];
                  opa_q    <= req_operand_a_i[grant_idx];
                  opb_q    <= req_operand_b_i[grant_idx];
                  gnt_id_q <= grant_idx;
                  rr_ptr_q <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               if (pe_cmd_ready_i) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (pe_done_i) begin
                  result_q <= pe_result_i;
                  state_q  <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (accept) begin
         req_ready_o[grant_idx] = 1'b1;
      end
      if (state_q == RESP) begin
         rsp_valid_o[gnt_id_q] = 1'b1;
      end
   end

   assign rsp_result_o   = (state_q == RESP) ? result_q : '0;
   assign rsp_id_o       = (state_q == RESP) ? gnt_id_q : '0;
   assign pe_cmd_valid_o = (state_q == ISSUE);
   assign pe_cmd_o       = cmd_q;
   assign pe_operand_a_o = opa_q;
   assign pe_operand_b_o = opb_q;
   assign busy_o         = (state_q != IDLE);

`ifdef NMCU_ARB_PERF_CNT_EN
   logic [PERF_CNT_WIDTH-1:0] perf_cnt_q [NUM_REQ];

   // Saturating grant counters; a clear in the same cycle as a grant takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            perf_cnt_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (perf_clr_i) begin
               perf_cnt_q[r] <= '0;
            end else if (accept && (grant_idx == ID_WIDTH'(r)) && (perf_cnt_q[r] != '1)) begin
               perf_cnt_q[r] <= perf_cnt_q[r] + 1'b1;
            end
         end
      end
   end

   assign perf_grant_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_pe_req_arbiter.sv
// Directed bench for pe_req_arbiter: table of transactions plus reset and stray-done sequences.
// Counter checks are included when NMCU_ARB_PERF_CNT_EN is defined.
module tb_pe_req_arbiter;
   import instr_pkg::*;

   localparam int NR = 4;
   localparam int DW = nmcu_pkg::DATA_WIDTH;
   localparam int IW = 2;

   logic          clk;
   logic          rst;
   logic [NR-1:0] req_valid_i;
   instruction_t  req_cmd_i       [NR];
   logic [DW-1:0] req_operand_a_i [NR];
   logic [DW-1:0] req_operand_b_i [NR];
   logic [NR-1:0] req_ready_o;
   logic [NR-1:0] rsp_valid_o;
   logic [DW-1:0] rsp_result_o;
   logic [IW-1:0] rsp_id_o;
   logic          pe_cmd_valid_o;
   instruction_t  pe_cmd_o;
   logic [DW-1:0] pe_operand_a_o;
   logic [DW-1:0] pe_operand_b_o;
   logic          pe_cmd_ready_i;
   logic          pe_done_i;
   logic [DW-1:0] pe_result_i;
   logic          busy_o;
`ifdef NMCU_ARB_PERF_CNT_EN
   logic          perf_clr_i;
   logic [31:0]   perf_grant_cnt_o [NR];
   bit            clrOnAccept;
`endif

   int checks;
   int errors;

   typedef struct {
      logic [NR-1:0] mask;
      logic [DW-1:0] opA;
      logic [DW-1:0] opB;
      logic [15:0]   cmd;
      int            delay;
      bit            strayDone;
      int            expGnt;
      logic [DW-1:0] expRes;
   } vec_t;

   vec_t vecs [13];

   pe_req_arbiter #(
      .NUM_REQ (NR)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid_i),
      .req_cmd_i       (req_cmd_i),
      .req_operand_a_i (req_operand_a_i),
      .req_operand_b_i (req_operand_b_i),
      .req_ready_o     (req_ready_o),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_result_o    (rsp_result_o),
      .rsp_id_o        (rsp_id_o),
      .pe_cmd_valid_o  (pe_cmd_valid_o),
      .pe_cmd_o        (pe_cmd_o),
      .pe_operand_a_o  (pe_operand_a_o),
      .pe_operand_b_o  (pe_operand_b_o),
      .pe_cmd_ready_i  (pe_cmd_ready_i),
      .pe_done_i       (pe_done_i),
      .pe_result_i     (pe_result_i),
`ifdef NMCU_ARB_PERF_CNT_EN
      .busy_o          (busy_o),
      .perf_clr_i      (perf_clr_i),
      .perf_grant_cnt_o(perf_grant_cnt_o)
`else
      .busy_o          (busy_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic setJunkOperands();
      for (int r = 0; r < NR; r++) begin
         req_cmd_i[r]       = instruction_t'(16'hF0F0 ^ 16'(r));
         req_operand_a_i[r] = 16'h5555 + 16'(r);
         req_operand_b_i[r] = 16'hAAA0 + 16'(r);
      end
   endtask

   // Runs one transaction starting at a falling edge with the DUT idle; ends idle at a falling edge.
   task automatic applyStimulus(input vec_t v);
      logic [NR-1:0] expMask;
      logic [15:0]   cmdBits;
      logic [DW-1:0] peA;
      logic [DW-1:0] peB;
      expMask = 4'b0001 << v.expGnt;
      peA     = '0;
      peB     = '0;
      setJunkOperands();
      req_cmd_i[v.expGnt]       = instruction_t'(v.cmd);
      req_operand_a_i[v.expGnt] = v.opA;
      req_operand_b_i[v.expGnt] = v.opB;
      req_valid_i               = v.mask;
`ifdef NMCU_ARB_PERF_CNT_EN
      perf_clr_i = clrOnAccept;
`endif
      #1;
      checkOutput("accept_ready", 32'(req_ready_o), 32'(expMask));
      @(negedge clk);
`ifdef NMCU_ARB_PERF_CNT_EN
      perf_clr_i = 1'b0;
`endif
      setJunkOperands();
      for (int k = 0; k <= v.delay; k++) begin
         if (k > 0) @(negedge clk);
         cmdBits = pe_cmd_o;
         checkOutput("issue_valid", 32'(pe_cmd_valid_o), 32'd1);
         checkOutput("issue_op_a", 32'(pe_operand_a_o), 32'(v.opA));
         checkOutput("issue_op_b", 32'(pe_operand_b_o), 32'(v.opB));
         checkOutput("issue_cmd", 32'(cmdBits), 32'(v.cmd));
         checkOutput("issue_no_ready", 32'(req_ready_o), 32'd0);
         peA            = pe_operand_a_o;
         peB            = pe_operand_b_o;
         pe_cmd_ready_i = (k == v.delay);
         if (v.strayDone) begin
            pe_done_i   = (k != v.delay);
            pe_result_i = 16'hDEAD;
         end
      end
      @(negedge clk);
      pe_cmd_ready_i = 1'b0;
      checkOutput("wait_valid", 32'(pe_cmd_valid_o), 32'd0);
      checkOutput("wait_busy", 32'(busy_o), 32'd1);
      checkOutput("wait_no_rsp", 32'(rsp_valid_o), 32'd0);
      pe_done_i   = 1'b1;
      pe_result_i = peA + peB;
      @(negedge clk);
      pe_done_i   = 1'b0;
      pe_result_i = 16'hDEAD;
      checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(expMask));
      checkOutput("rsp_id", 32'(rsp_id_o), 32'(v.expGnt));
      checkOutput("rsp_result", 32'(rsp_result_o), 32'(v.expRes));
      @(negedge clk);
      checkOutput("idle_no_rsp", 32'(rsp_valid_o), 32'd0);
      checkOutput("idle_result_zero", 32'(rsp_result_o), 32'd0);
      checkOutput("idle_busy", 32'(busy_o), 32'd0);
      req_valid_i = '0;
   endtask

   initial begin
      vec_t finalVec;
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      req_valid_i    = 4'b1111;
      pe_cmd_ready_i = 1'b0;
      pe_done_i      = 1'b0;
      pe_result_i    = '0;
`ifdef NMCU_ARB_PERF_CNT_EN
      perf_clr_i  = 1'b0;
      clrOnAccept = 1'b0;
`endif
      setJunkOperands();

      //           mask     opA       opB       cmd      dly stray gnt  result
      vecs[0]  = '{4'b1111, 16'd10,   16'd3,    16'h1101, 0, 1'b0, 0, 16'd13};
      vecs[1]  = '{4'b1111, 16'd20,   16'd4,    16'h1202, 0, 1'b0, 1, 16'd24};
      vecs[2]  = '{4'b1111, 16'd30,   16'd5,    16'h1303, 0, 1'b0, 2, 16'd35};
      vecs[3]  = '{4'b1111, 16'd40,   16'd6,    16'h1404, 0, 1'b0, 3, 16'd46};
      vecs[4]  = '{4'b1111, 16'd100,  16'd200,  16'h2105, 0, 1'b0, 0, 16'd300};
      vecs[5]  = '{4'b1111, 16'hFFFF, 16'd2,    16'h2206, 0, 1'b0, 1, 16'd1};
      vecs[6]  = '{4'b1111, 16'h1234, 16'h1111, 16'h2307, 0, 1'b0, 2, 16'h2345};
      vecs[7]  = '{4'b1111, 16'h8000, 16'h8000, 16'h2408, 0, 1'b0, 3, 16'h0000};
      vecs[8]  = '{4'b0010, 16'd5,    16'd7,    16'h3A11, 0, 1'b0, 1, 16'd12};
      vecs[9]  = '{4'b0011, 16'h00AA, 16'h0055, 16'h4B22, 0, 1'b0, 0, 16'h00FF};
      vecs[10] = '{4'b1001, 16'h1000, 16'h0234, 16'h5C33, 0, 1'b0, 3, 16'h1234};
      vecs[11] = '{4'b0100, 16'h0F0F, 16'hF0F0, 16'h6D44, 3, 1'b1, 2, 16'hFFFF};
      vecs[12] = '{4'b0101, 16'd7,    16'd9,    16'h7E55, 0, 1'b0, 0, 16'd16};

      #3;
      checkOutput("reset_ready", 32'(req_ready_o), 32'd0);
      checkOutput("reset_busy", 32'(busy_o), 32'd0);
      checkOutput("reset_pe_valid", 32'(pe_cmd_valid_o), 32'd0);
      checkOutput("reset_rsp", 32'(rsp_valid_o), 32'd0);
      checkOutput("reset_op_a", 32'(pe_operand_a_o), 32'd0);
      @(negedge clk);
      rst         = 1'b0;
      req_valid_i = '0;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         if (i == 9) begin
            pe_done_i   = 1'b1;
            pe_result_i = 16'hDEAD;
            @(negedge clk);
            pe_done_i = 1'b0;
            checkOutput("stray_no_rsp", 32'(rsp_valid_o), 32'd0);
            checkOutput("stray_busy", 32'(busy_o), 32'd0);
         end
         applyStimulus(vecs[i]);
      end

      // Reset while waiting on the PE: the command is dropped and the pointer restarts at 0.
      setJunkOperands();
      req_operand_a_i[1] = 16'd1;
      req_operand_b_i[1] = 16'd2;
      req_valid_i        = 4'b0010;
      #1;
      checkOutput("rstseq_accept", 32'(req_ready_o), 32'b0010);
      @(negedge clk);
      req_valid_i    = '0;
      pe_cmd_ready_i = 1'b1;
      @(negedge clk);
      pe_cmd_ready_i = 1'b0;
      checkOutput("rstseq_in_wait", 32'(busy_o), 32'd1);
      #2;
      rst         = 1'b1;
      req_valid_i = 4'b1111;
      pe_done_i   = 1'b1;
      pe_result_i = 16'hDEAD;
      #1;
      checkOutput("rstseq_busy", 32'(busy_o), 32'd0);
      checkOutput("rstseq_ready", 32'(req_ready_o), 32'd0);
      checkOutput("rstseq_rsp", 32'(rsp_valid_o), 32'd0);
      checkOutput("rstseq_pe_valid", 32'(pe_cmd_valid_o), 32'd0);
      checkOutput("rstseq_op_a", 32'(pe_operand_a_o), 32'd0);
      @(negedge clk);
      rst         = 1'b0;
      pe_done_i   = 1'b0;
      req_valid_i = '0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("rstseq_no_rsp", 32'(rsp_valid_o), 32'd0);
      end
      finalVec = '{4'b1111, 16'd3, 16'd4, 16'h0F01, 0, 1'b0, 0, 16'd7};
      applyStimulus(finalVec);

`ifdef NMCU_ARB_PERF_CNT_EN
      perf_clr_i = 1'b1;
      @(negedge clk);
      perf_clr_i = 1'b0;
      for (int r = 0; r < NR; r++) begin
         checkOutput("perf_clear", perf_grant_cnt_o[r], 32'd0);
      end
      finalVec = '{4'b0100, 16'd1, 16'd1, 16'h0202, 0, 1'b0, 2, 16'd2};
      applyStimulus(finalVec);
      checkOutput("perf_cnt_one", perf_grant_cnt_o[2], 32'd1);
      applyStimulus(finalVec);
      applyStimulus(finalVec);
      checkOutput("perf_cnt_three", perf_grant_cnt_o[2], 32'd3);
      checkOutput("perf_cnt_other", perf_grant_cnt_o[0], 32'd0);
      perf_clr_i = 1'b1;
      @(negedge clk);
      perf_clr_i = 1'b0;
      checkOutput("perf_clr_pulse", perf_grant_cnt_o[2], 32'd0);
      clrOnAccept = 1'b1;
      applyStimulus(finalVec);
      clrOnAccept = 1'b0;
      checkOutput("perf_clr_wins", perf_grant_cnt_o[2], 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
